// File: rtl/pcie_pkg.sv
// rtl/pcie_pkg.sv - symbol codes and receive FSM encoding shared by pcie_cond and the deframer
package pcie_pkg;

  localparam logic [7:0] SYM_COM = 8'hBC;
  localparam logic [7:0] SYM_PAD = 8'hF7;
  localparam logic [7:0] SYM_SKP = 8'h1C;
  localparam logic [7:0] SYM_STP = 8'hFB;
  localparam logic [7:0] SYM_SDP = 8'h5C;
  localparam logic [7:0] SYM_END = 8'hFD;
  localparam logic [7:0] SYM_EDB = 8'hFE;
  localparam logic [7:0] SYM_FTS = 8'h3C;
  localparam logic [7:0] SYM_IDL = 8'h7C;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_OS_COM = 3'd1,
    ST_OS_SKP = 3'd2,
    ST_OS_FTS = 3'd3,
    ST_PKT    = 3'd4,
    ST_DROP   = 3'd5
  } rx_state_e;

  function automatic logic is_pkt_end(input logic [7:0] sym);
    return (sym == SYM_END) || (sym == SYM_EDB);
  endfunction

endpackage

// File: rtl/pcie_rx_os_detect.sv
// rtl/pcie_rx_os_detect.sv - SKP/FTS ordered-set counter; proposes next state and pulses for the top
module pcie_rx_os_detect
  import pcie_pkg::*;
#(
  parameter int OS_LEN = 3
) (
  input  logic       i_clk,
  input  logic       i_resetn,
  input  logic       i_enb,
  input  rx_state_e  i_state,
  input  logic [7:0] i_data,
  output rx_state_e  o_next_state,
  output logic       o_skp_os,
  output logic       o_fts_os,
  output logic       o_err
);

  localparam logic [3:0] OS_LEN_C = 4'(OS_LEN);

  logic [3:0] r_cnt;
  logic [3:0] w_cnt_nxt;
  logic       w_skp_ok;
  logic       w_fts_ok;
  logic       w_in_os;
  logic       w_done;

  // Count including the symbol now being consumed; COM restarts the count.
  assign w_cnt_nxt = (i_state == ST_OS_COM) ? 4'd1 : r_cnt + 4'd1;
  assign w_done    = (w_cnt_nxt == OS_LEN_C);
  assign w_in_os   = (i_state == ST_OS_COM) || (i_state == ST_OS_SKP) || (i_state == ST_OS_FTS);
  assign w_skp_ok  = (i_data == SYM_SKP) && ((i_state == ST_OS_COM) || (i_state == ST_OS_SKP));
  assign w_fts_ok  = (i_data == SYM_FTS) && ((i_state == ST_OS_COM) || (i_state == ST_OS_FTS));

  always_comb begin
    o_next_state = ST_IDLE;
    o_skp_os     = 1'b0;
    o_fts_os     = 1'b0;
    o_err        = 1'b0;
    if (w_skp_ok) begin
      if (w_done) o_skp_os = 1'b1;
      else        o_next_state = ST_OS_SKP;
    end else if (w_fts_ok) begin
      if (w_done) o_fts_os = 1'b1;
      else        o_next_state = ST_OS_FTS;
    end else if (w_in_os) begin
      o_err = 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_resetn) begin
      r_cnt <= '0;
    end else if (i_enb) begin
      r_cnt <= ((o_next_state == ST_OS_SKP) || (o_next_state == ST_OS_FTS)) ? w_cnt_nxt : 4'd0;
    end
  end

endmodule

// File: rtl/pcie_rx_deframer.sv
// rtl/pcie_rx_deframer.sv - strips STP/SDP framing into SOP/EOP byte stream, flags OS/idle/errors
// PCIE_DEFRAMER_STATS_EN adds saturating OUT_PKT_CNT / OUT_ERR_CNT counters.
module pcie_rx_deframer
  import pcie_pkg::*;
#(
  parameter int MAX_LEN  = 32,
  parameter int DLLP_LEN = 6,
  parameter int OS_LEN   = 3
) (
  input  logic        IN_CLK_2MHz,
  input  logic        IN_RESET_CLK,
  input  logic        IN_ENB_TX_RX,
  input  logic [7:0]  IN_DATA,
  output logic [7:0]  OUT_DATA,
  output logic        OUT_VALID,
  output logic        OUT_SOP,
  output logic        OUT_EOP,
  output logic        OUT_PKT_DLLP,
  output logic        OUT_PKT_ERR,
  output logic        OUT_FRAME_ERR,
  output logic        OUT_SKP_OS,
  output logic        OUT_FTS_OS,
  output logic        OUT_IDLE
`ifdef PCIE_DEFRAMER_STATS_EN
  ,
  output logic [15:0] OUT_PKT_CNT,
  output logic [7:0]  OUT_ERR_CNT
`endif
);

  localparam logic [5:0] MAX_LEN_C  = 6'(MAX_LEN);
  localparam logic [5:0] DLLP_LEN_C = 6'(DLLP_LEN);

  rx_state_e  r_state;
  logic [7:0] r_hold;
  logic [5:0] r_cnt;
  logic       r_dllp;

  rx_state_e  w_os_next;
  logic       w_os_skp;
  logic       w_os_fts;
  logic       w_os_err;
  logic       w_pkt_end;
  logic       w_over;
  logic       w_emit;
  logic       w_eop;
  logic       w_err;

  pcie_rx_os_detect #(.OS_LEN(OS_LEN)) u_os_detect (
    .i_clk        (IN_CLK_2MHz),
    .i_resetn     (IN_RESET_CLK),
    .i_enb        (IN_ENB_TX_RX),
    .i_state      (r_state),
    .i_data       (IN_DATA),
    .o_next_state (w_os_next),
    .o_skp_os     (w_os_skp),
    .o_fts_os     (w_os_fts),
    .o_err        (w_os_err)
  );

  // Any symbol consumed in PKT releases the held byte; r_cnt is the hold-reg occupancy too.
  assign w_pkt_end = is_pkt_end(IN_DATA);
  assign w_over    = !w_pkt_end && (r_cnt >= MAX_LEN_C);
  assign w_emit    = (r_state == ST_PKT) && (r_cnt != 6'd0);
  assign w_eop     = w_pkt_end || w_over;
  assign w_err     = w_over || (w_pkt_end && ((IN_DATA == SYM_EDB) || (r_dllp && (r_cnt != DLLP_LEN_C))));

  always_ff @(posedge IN_CLK_2MHz) begin
    if (!IN_RESET_CLK) begin
      r_state       <= ST_IDLE;
      r_hold        <= '0;
      r_cnt         <= '0;
      r_dllp        <= 1'b0;
      OUT_DATA      <= '0;
      OUT_VALID     <= 1'b0;
      OUT_SOP       <= 1'b0;
      OUT_EOP       <= 1'b0;
      OUT_PKT_DLLP  <= 1'b0;
      OUT_PKT_ERR   <= 1'b0;
      OUT_FRAME_ERR <= 1'b0;
      OUT_SKP_OS    <= 1'b0;
      OUT_FTS_OS    <= 1'b0;
      OUT_IDLE      <= 1'b0;
    end else begin
      OUT_VALID     <= 1'b0;
      OUT_SOP       <= 1'b0;
      OUT_EOP       <= 1'b0;
      OUT_PKT_ERR   <= 1'b0;
      OUT_FRAME_ERR <= 1'b0;
      OUT_SKP_OS    <= 1'b0;
      OUT_FTS_OS    <= 1'b0;
      if (IN_ENB_TX_RX) begin
        OUT_IDLE <= (r_state == ST_IDLE) && (IN_DATA == SYM_IDL);
        if (w_emit) begin
          OUT_VALID    <= 1'b1;
          OUT_DATA     <= r_hold;
          OUT_SOP      <= (r_cnt == 6'd1);
          OUT_EOP      <= w_eop;
          OUT_PKT_ERR  <= w_err;
          OUT_PKT_DLLP <= r_dllp;
        end
        case (r_state)
          ST_IDLE: begin
            r_cnt <= '0;
            case (IN_DATA)
              SYM_COM: r_state <= ST_OS_COM;
              SYM_STP: begin
                r_state <= ST_PKT;
                r_dllp  <= 1'b0;
              end
              SYM_SDP: begin
                r_state <= ST_PKT;
                r_dllp  <= 1'b1;
              end
              SYM_IDL, SYM_PAD: ;
              default: OUT_FRAME_ERR <= 1'b1;
            endcase
          end
          ST_OS_COM, ST_OS_SKP, ST_OS_FTS: begin
            r_state       <= w_os_next;
            OUT_SKP_OS    <= w_os_skp;
            OUT_FTS_OS    <= w_os_fts;
            OUT_FRAME_ERR <= w_os_err;
          end
          ST_PKT: begin
            if (w_pkt_end) begin
              r_state <= ST_IDLE;
              if (r_cnt == 6'd0) OUT_FRAME_ERR <= 1'b1;
            end else if (w_over) begin
              r_state <= ST_DROP;
            end else begin
              r_hold <= IN_DATA;
              r_cnt  <= (r_cnt == '1) ? r_cnt : r_cnt + 6'd1;
            end
          end
          ST_DROP: begin
            if (w_pkt_end) r_state <= ST_IDLE;
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

`ifdef PCIE_DEFRAMER_STATS_EN
  always_ff @(posedge IN_CLK_2MHz) begin
    if (!IN_RESET_CLK) begin
      OUT_PKT_CNT <= '0;
      OUT_ERR_CNT <= '0;
    end else begin
      if (OUT_EOP && (OUT_PKT_CNT != '1)) OUT_PKT_CNT <= OUT_PKT_CNT + 16'd1;
      if ((OUT_PKT_ERR || OUT_FRAME_ERR) && (OUT_ERR_CNT != '1)) OUT_ERR_CNT <= OUT_ERR_CNT + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pcie_rx_deframer.sv
// tb/tb_pcie_rx_deframer.sv - directed and randomized bench for pcie_rx_deframer
`timescale 1ns/1ps
module tb_pcie_rx_deframer;

  localparam logic [7:0] C_COM = 8'hBC, C_PAD = 8'hF7, C_SKP = 8'h1C, C_STP = 8'hFB;
  localparam logic [7:0] C_SDP = 8'h5C, C_END = 8'hFD, C_EDB = 8'hFE, C_FTS = 8'h3C, C_IDL = 8'h7C;
  localparam int MAXL = 32;

  logic       IN_CLK_2MHz = 1'b0;
  logic       IN_RESET_CLK;
  logic       IN_ENB_TX_RX;
  logic [7:0] IN_DATA;
  logic [7:0] OUT_DATA;
  logic       OUT_VALID, OUT_SOP, OUT_EOP, OUT_PKT_DLLP, OUT_PKT_ERR;
  logic       OUT_FRAME_ERR, OUT_SKP_OS, OUT_FTS_OS, OUT_IDLE;

  pcie_rx_deframer dut (
    .IN_CLK_2MHz   (IN_CLK_2MHz),
    .IN_RESET_CLK  (IN_RESET_CLK),
    .IN_ENB_TX_RX  (IN_ENB_TX_RX),
    .IN_DATA       (IN_DATA),
    .OUT_DATA      (OUT_DATA),
    .OUT_VALID     (OUT_VALID),
    .OUT_SOP       (OUT_SOP),
    .OUT_EOP       (OUT_EOP),
    .OUT_PKT_DLLP  (OUT_PKT_DLLP),
    .OUT_PKT_ERR   (OUT_PKT_ERR),
    .OUT_FRAME_ERR (OUT_FRAME_ERR),
    .OUT_SKP_OS    (OUT_SKP_OS),
    .OUT_FTS_OS    (OUT_FTS_OS),
    .OUT_IDLE      (OUT_IDLE)
  );

  always #250 IN_CLK_2MHz = ~IN_CLK_2MHz;

  typedef logic [11:0] rec_t; // {data, sop, eop, err, dllp}
  rec_t obs_q[$];
  rec_t exp_q[$];
  int   n_checks = 0;
  int   n_pass = 0;
  int   obs_ferr, obs_skp, obs_fts;
  int   item_no = 0;
  bit   stall_en = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s item %0d: observed %0h expected %0h", tag, item_no, obs, exp);
  endtask

  task automatic tick(input logic enb, input logic [7:0] d);
    IN_ENB_TX_RX = enb;
    IN_DATA      = d;
    @(posedge IN_CLK_2MHz);
    @(negedge IN_CLK_2MHz);
    if (OUT_VALID) obs_q.push_back({OUT_DATA, OUT_SOP, OUT_EOP, OUT_PKT_ERR, OUT_PKT_DLLP});
    obs_ferr += int'(OUT_FRAME_ERR);
    obs_skp  += int'(OUT_SKP_OS);
    obs_fts  += int'(OUT_FTS_OS);
    if (!enb)
      check("stall_quiet", {25'd0, OUT_VALID, OUT_SOP, OUT_EOP, OUT_PKT_ERR, OUT_FRAME_ERR, OUT_SKP_OS, OUT_FTS_OS}, 32'd0);
  endtask

  task automatic send(input logic [7:0] d);
    if (stall_en && ($urandom_range(0, 9) == 0))
      repeat ($urandom_range(1, 3)) tick(1'b0, 8'($urandom_range(0, 255)));
    tick(1'b1, d);
  endtask

  function automatic logic [7:0] rand_payload();
    logic [7:0] g;
    g = 8'($urandom_range(0, 255));
    if (g == C_END || g == C_EDB) g = 8'h42;
    return g;
  endfunction

  function automatic logic [7:0] rand_garbage();
    logic [7:0] g;
    g = 8'($urandom_range(0, 255));
    while (g == C_COM || g == C_STP || g == C_SDP || g == C_IDL || g == C_PAD) g = g + 8'd1;
    return g;
  endfunction

  task automatic clear_obs();
    obs_q.delete();
    exp_q.delete();
    obs_ferr = 0;
    obs_skp  = 0;
    obs_fts  = 0;
  endtask

  // kind: 0 TLP, 1 DLLP, 2 SKP OS, 3 FTS OS, 4 IDL run, 5 PAD, 6 stray symbol, 7 broken OS
  task automatic run_item(input int kind, input int len, input bit edb);
    int   e_ferr, e_skp, e_fts, n_out;
    bit   e_idle, dllp, perr, last;
    logic [7:0] b;
    clear_obs();
    item_no++;
    e_ferr = 0; e_skp = 0; e_fts = 0; e_idle = 1'b0;
    case (kind)
      0, 1: begin
        dllp  = (kind == 1);
        n_out = (len > MAXL) ? MAXL : len;
        perr  = (len > MAXL) || edb || (dllp && len != 6);
        send(dllp ? C_SDP : C_STP);
        for (int i = 0; i < len; i++) begin
          b = rand_payload();
          send(b);
          if (i < n_out) begin
            last = (i == n_out - 1);
            exp_q.push_back({b, (i == 0), last, last && perr, dllp});
          end
        end
        send(edb ? C_EDB : C_END);
        e_ferr = (len == 0) ? 1 : 0;
      end
      2, 3: begin
        send(C_COM);
        repeat (3) send(kind == 2 ? C_SKP : C_FTS);
        if (kind == 2) e_skp = 1; else e_fts = 1;
      end
      4: begin
        repeat (len) send(C_IDL);
        e_idle = 1'b1;
      end
      5: send(C_PAD);
      6: begin
        send(rand_garbage());
        e_ferr = 1;
      end
      default: begin
        send(C_COM);
        repeat (len) send(C_SKP);
        b = 8'($urandom_range(0, 255));
        while (b == C_SKP || (len == 0 && b == C_FTS)) b = b + 8'd1;
        send(b);
        e_ferr = 1;
      end
    endcase
    check("byte_count", 32'(obs_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) check("byte", 32'(obs_q[i]), 32'(exp_q[i]));
    check("pulse_counts", {8'd0, obs_ferr[7:0], obs_skp[7:0], obs_fts[7:0]}, {8'd0, e_ferr[7:0], e_skp[7:0], e_fts[7:0]});
    check("idle_level", 32'(OUT_IDLE), 32'(e_idle));
  endtask

  initial begin
    int kind, len;
    bit edb;
    IN_RESET_CLK = 1'b0;
    IN_ENB_TX_RX = 1'b0;
    IN_DATA      = 8'h00;
    repeat (3) @(negedge IN_CLK_2MHz);
    check("reset_outputs", {14'd0, OUT_DATA, OUT_VALID, OUT_SOP, OUT_EOP, OUT_PKT_DLLP, OUT_PKT_ERR,
                            OUT_FRAME_ERR, OUT_SKP_OS, OUT_FTS_OS, OUT_IDLE, 1'b0}, 32'd0);
    IN_RESET_CLK = 1'b1;
    clear_obs();

    // Exact latency: payload byte surfaces on the sample after the next accepted symbol.
    tick(1'b1, C_STP);
    tick(1'b1, 8'h11);
    check("lat_first_hidden", 32'(OUT_VALID), 32'd0);
    tick(1'b1, 8'h22);
    check("lat_sop", {22'd0, OUT_VALID, OUT_DATA, OUT_SOP, OUT_EOP}, {22'd0, 1'b1, 8'h11, 1'b1, 1'b0});
    tick(1'b1, 8'h33);
    tick(1'b1, C_END);
    check("lat_eop", {21'd0, OUT_VALID, OUT_DATA, OUT_EOP, OUT_PKT_ERR, OUT_PKT_DLLP},
          {21'd0, 1'b1, 8'h33, 1'b1, 1'b0, 1'b0});

    tick(1'b1, C_COM);
    tick(1'b1, C_SKP);
    tick(1'b1, C_SKP);
    check("skp_early", 32'(OUT_SKP_OS), 32'd0);
    tick(1'b1, C_SKP);
    check("skp_pulse", {30'd0, OUT_SKP_OS, OUT_FRAME_ERR}, {30'd0, 1'b1, 1'b0});
    tick(1'b1, C_IDL);
    check("skp_one_cycle", {30'd0, OUT_SKP_OS, OUT_IDLE}, {30'd0, 1'b0, 1'b1});

    // Stall mid-TLP: stream content unchanged.
    clear_obs();
    tick(1'b1, C_STP);
    tick(1'b1, 8'hA1);
    tick(1'b1, 8'hA2);
    repeat (3) tick(1'b0, C_END);
    tick(1'b1, 8'hA3);
    tick(1'b1, C_END);
    check("stall_count", 32'(obs_q.size()), 32'd3);
    if (obs_q.size() == 3) begin
      check("stall_b0", 32'(obs_q[0]), {20'd0, 8'hA1, 4'b1000});
      check("stall_b2", 32'(obs_q[2]), {20'd0, 8'hA3, 4'b0100});
    end

    // Reset mid-packet: no EOP; the following END is a stray symbol.
    tick(1'b1, C_STP);
    tick(1'b1, 8'hAA);
    tick(1'b1, 8'hBB);
    IN_RESET_CLK = 1'b0;
    tick(1'b1, 8'hCC);
    check("reset_mid_pkt", {29'd0, OUT_VALID, OUT_EOP, OUT_FRAME_ERR}, 32'd0);
    IN_RESET_CLK = 1'b1;
    tick(1'b1, C_END);
    check("post_reset_end", {30'd0, OUT_VALID, OUT_FRAME_ERR}, {30'd0, 1'b0, 1'b1});

    run_item(0, 3, 1'b0);
    run_item(1, 6, 1'b0);
    run_item(1, 5, 1'b0);
    run_item(0, 2, 1'b1);
    run_item(0, 0, 1'b0);
    run_item(0, 1, 1'b0);
    run_item(0, 40, 1'b0);
    run_item(0, 32, 1'b0);
    run_item(0, 3, 1'b0);
    run_item(3, 0, 1'b0);
    run_item(7, 2, 1'b0);
    run_item(4, 2, 1'b0);

    stall_en = 1'b1;
    for (int k = 0; k < 120; k++) begin
      kind = $urandom_range(0, 7);
      edb  = ($urandom_range(0, 3) == 0);
      case (kind)
        0:       len = ($urandom_range(0, 3) == 0) ? $urandom_range(28, 40) : $urandom_range(0, 10);
        1:       len = $urandom_range(0, 8);
        4:       len = $urandom_range(1, 3);
        7:       len = $urandom_range(0, 2);
        default: len = 0;
      endcase
      run_item(kind, len, edb);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
